// File: rtl/duc_if.sv
// ---------------------------------------------------------------------------
// duc_if
//   Input sample stream into the digital up-converter: one complex baseband
//   I/Q pair per accepted transfer (s_valid && s_ready).
//
//   s_valid   master -> slave  sample valid
//   s_ready   slave  -> master FIFO has room for one more pair
//   s_data_I  master -> slave  16-bit two's-complement I sample
//   s_data_Q  master -> slave  16-bit two's-complement Q sample
// ---------------------------------------------------------------------------
interface duc_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data_I;
  logic [15:0] s_data_Q;

  modport master (
    output s_valid,
    output s_data_I,
    output s_data_Q,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data_I,
    input  s_data_Q,
    output s_ready
  );
endinterface

// File: rtl/duc.sv
// ---------------------------------------------------------------------------
// duc
//   Digital up-converter for the radar transmit path. Complex I/Q samples are
//   queued in a small FIFO, interpolated by zero-order hold (INTERP outputs per
//   input) and mixed up to fs/4, which reduces the NCO to sign/swap:
//     phase 0 -> I, 1 -> -Q, 2 -> -I, 3 -> +Q  (negation saturates).
//   One real output sample is produced per duc_en strobe while running.
//
//   Parameters
//     INTERP      output samples per input sample (power of 2, 2..16)
//     FIFO_DEPTH  input FIFO depth in I/Q pairs (power of 2, >= 2)
//
//   Ports
//     clk_duc        block clock
//     reset_n        asynchronous active-low reset
//     duc_en         output-rate clock-enable strobe
//     tx_start       single-cycle request to begin transmission
//     tx_stop        single-cycle request to drain and stop
//     s_bus          sample input stream (duc_if.slave)
//     data_out       registered real output sample
//     data_out_valid one-cycle pulse per output sample
//     busy           high in PRIME, RUN and DRAIN
//     underflow      one-cycle pulse on a starved fetch
//     underflow_cnt  saturating starved-fetch count, cleared only by reset
// ---------------------------------------------------------------------------
module duc #(
  parameter int INTERP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_duc,
  input  logic        reset_n,
  input  logic        duc_en,
  input  logic        tx_start,
  input  logic        tx_stop,
  duc_if.slave        s_bus,
  output logic [15:0] data_out,
  output logic        data_out_valid,
  output logic        busy,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(INTERP);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic [15:0]   fifo_i [FIFO_DEPTH];
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [15:0]   hold_i;
  logic [15:0]   hold_q;
  logic [1:0]    phase;
  logic [IW-1:0] icnt;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          active;
  logic          drain_done;

  logic [15:0]   sel_i;
  logic [15:0]   sel_q;
  logic          starved;

  // Two's-complement negate that maps -32768 to +32767 instead of wrapping.
  function automatic logic [15:0] sat_neg(input logic [15:0] x);
    if (x == 16'h8000) begin
      return 16'h7FFF;
    end
    return ~x + 16'd1;
  endfunction

  // fs/4 mixer: I*cos - Q*sin with cos/sin taking only 0/+1/-1.
  function automatic logic [15:0] mix(input logic [15:0] si, input logic [15:0] sq,
                                      input logic [1:0] ph);
    case (ph)
      2'd0:    return si;
      2'd1:    return sat_neg(sq);
      2'd2:    return sat_neg(si);
      default: return sq;
    endcase
  endfunction

  assign fifo_full     = (count == CW'(FIFO_DEPTH));
  assign fifo_empty    = (count == '0);
  assign s_bus.s_ready = !fifo_full;
  assign push          = s_bus.s_valid && !fifo_full;
  assign active        = (state == RUN) || (state == DRAIN);

  // DRAIN finishes on a fetch slot with nothing left to fetch; that strobe
  // produces no output and is not an underflow.
  assign drain_done = (state == DRAIN) && (icnt == '0) && fifo_empty;
  assign pop        = active && duc_en && (icnt == '0) && !fifo_empty;

  // A new sample is fetched only at the start of each hold interval; in
  // between, the held sample is re-used. A fetch from an empty FIFO yields 0.
  always_comb begin
    sel_i   = hold_i;
    sel_q   = hold_q;
    starved = 1'b0;
    if (icnt == '0) begin
      if (fifo_empty) begin
        sel_i   = '0;
        sel_q   = '0;
        starved = 1'b1;
      end else begin
        sel_i = fifo_i[rd_ptr];
        sel_q = fifo_q[rd_ptr];
      end
    end
  end

  // Input FIFO. Writes are accepted in every state, so the FIFO can be
  // prefilled while idle; contents survive IDLE and only reset clears them.
  always_ff @(posedge clk_duc or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_i[k] <= '0;
        fifo_q[k] <= '0;
      end
    end else begin
      if (push) begin
        fifo_i[wr_ptr] <= s_bus.s_data_I;
        fifo_q[wr_ptr] <= s_bus.s_data_Q;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control FSM with all outputs registered. busy is written alongside each
  // state change so it already reflects the state being entered.
  always_ff @(posedge clk_duc or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      hold_i         <= '0;
      hold_q         <= '0;
      phase          <= '0;
      icnt           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
      underflow_cnt  <= '0;
    end else begin
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start && !tx_stop) begin
            state <= PRIME;
            busy  <= 1'b1;
          end
        end
        PRIME: begin
          if (tx_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (count >= CW'(2)) begin
            state <= RUN;
            phase <= '0;
            icnt  <= '0;
          end
        end
        RUN, DRAIN: begin
          if (state == RUN && tx_stop) begin
            state <= DRAIN;
          end
          if (duc_en) begin
            if (drain_done) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              hold_i         <= sel_i;
              hold_q         <= sel_q;
              phase          <= phase + 2'd1;
              icnt           <= icnt + IW'(1);
              data_out       <= mix(sel_i, sel_q, phase);
              data_out_valid <= 1'b1;
              if (starved) begin
                underflow <= 1'b1;
                if (underflow_cnt != 16'hFFFF) begin
                  underflow_cnt <= underflow_cnt + 16'd1;
                end
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/duc.md
# duc

Digital up-converter for the radar transmit path; the counterpart of the receive-side DDC. It accepts complex baseband I/Q samples over a valid/ready handshake and buffers them in a small FIFO. It interpolates each sample by zero-order hold and mixes it up to fs/4, using the same 0x40000000 NCO word as the receive side, so mixing reduces to sign and swap. The output is a real 16-bit sample stream toward the DAC, one sample per output-rate enable strobe.

## Interface
- INTERP, 4: output samples per input sample; power of 2, range 2–16.
- FIFO_DEPTH, 4: input FIFO depth in I/Q pairs; power of 2, minimum 2.

- clk_duc  in  1  single block clock.
- reset_n  in  1  asynchronous, active-low reset.
- duc_en  in  1  output-rate clock-enable strobe; any duty cycle.
- tx_start  in  1  single-cycle request to begin transmission.
- tx_stop  in  1  single-cycle request to drain and stop.
- s_valid  in  1  input sample valid.
- s_ready  out  1  FIFO can accept a sample; equals !full; combinational from the registered count.
- s_data_I  in  16  input I sample, two's complement.
- s_data_Q  in  16  input Q sample, two's complement.
- data_out  out  16  real up-converted sample, two's complement, registered.
- data_out_valid  out  1  one-cycle pulse per output sample.
- busy  out  1  high in PRIME, RUN and DRAIN.
- underflow  out  1  one-cycle pulse on a starved fetch.
- underflow_cnt  out  16  starved-fetch count; saturates at 0xFFFF; cleared only by reset.

## Operation
- **FIFO writes.** A push occurs when s_valid && s_ready, in any state, including prefill in IDLE.
- **FIFO pops.** Only the fetch rule below pops the FIFO.
- **Simultaneous push and pop.** The count is unchanged.
- **Persistence.** FIFO contents persist across IDLE and are cleared only by reset.
- **States:** IDLE, PRIME, RUN, DRAIN.
- **IDLE.**
  - tx_start → PRIME.
  - If tx_start and tx_stop arrive in the same cycle, stop wins and the block stays in IDLE.
- **PRIME.**
  - When the FIFO count ≥ 2 → RUN. On this transition, clear phase and icnt to 0.
  - tx_stop → IDLE.
  - tx_start is ignored.
- **RUN, on each duc_en cycle:**
  - Sample selection:
    - If icnt==0: S = FIFO head and pop. If the FIFO is empty, S = 0, pulse underflow and increment underflow_cnt.
    - Otherwise S = hold.
  - Register updates: hold←S, phase←phase+1 (mod 4), icnt←icnt+1 (mod INTERP).
  - Output: data_out←mix(S, phase), data_out_valid←1.
  - Cycles without duc_en leave all of the above unchanged.
- **mix(S, phase).** The NCO is cos/sin at fs/4 and the output is I·cos − Q·sin.
  - phase 0 → I.
  - phase 1 → −Q.
  - phase 2 → −I.
  - phase 3 → +Q.
  - Negation saturates: −(−32768) = 32767. No other arithmetic and no growth beyond 16 bits.
- **tx_stop in RUN → DRAIN.** DRAIN behaves exactly as RUN, with one exception:
  - On a duc_en cycle with icnt==0 and the FIFO empty, the block emits no output, does not flag underflow, and goes to IDLE.
  - The current held sample therefore always completes its INTERP outputs.
  - tx_start is ignored in DRAIN.

## Timing
- **Reset values.** All outputs are 0 except s_ready = 1. State IDLE; FIFO, hold, phase, icnt and underflow_cnt are all 0.
- **Reset mid-operation.** Asserting reset_n low forces the reset values immediately, without waiting for a clock edge; nothing from before the reset is retained.
- **Output latency.** data_out and data_out_valid update on the clk_duc edge that samples duc_en=1, and are therefore visible the cycle after the strobe.
- **Output hold.** data_out holds its value between pulses. data_out_valid is 0 in IDLE and PRIME.
- **PRIME exit.** PRIME→RUN takes 1 cycle after the count reaches 2; a duc_en in that same cycle is ignored.
- **underflow.** The pulse is coincident with the data_out_valid carrying the zero sample.
- **busy** is a registered decode of state. It drops on the edge that enters IDLE.
- **s_ready reopening.** With the FIFO full, a pop reasserts s_ready in the next cycle.

## Test plan
- **Basic up-conversion.**
  - Stimulus: push (I=1000, Q=200) and (I=−500, Q=300); pulse tx_start; pulse duc_en every 3rd cycle for 8 strobes.
  - Required data_out: 1000, −200, −1000, 200, −500, −300, 500, 300.
  - Required ancillary: 8 valid pulses, each one cycle after its strobe; busy high.
- **Underflow.**
  - Stimulus: same two samples, 12 strobes.
  - Required: outputs 9–12 are 0; underflow pulses once, at output 9; underflow_cnt = 1.
  - Continue to 16 strobes → underflow_cnt = 2.
- **Saturation.**
  - Stimulus: push (−32768, −32768), plus one filler sample so PRIME exits.
  - Required: the first four outputs are −32768, 32767, 32767, −32768.
- **Backpressure.**
  - Stimulus: in IDLE, hold s_valid with 5 distinct samples.
  - Required: s_ready falls after the 4th push.
  - Then tx_start and one strobe: s_ready returns next cycle, the 5th sample is accepted, and outputs follow FIFO order.
- **Drain.**
  - Stimulus: 3 samples queued, RUN; pulse tx_stop after output 2.
  - Required: exactly 12 outputs total, then IDLE with busy=0, underflow_cnt=0, and no further valids.
  - Also: a simultaneous tx_start+tx_stop in IDLE leaves busy=0.
- **Async reset mid-RUN.**
  - Stimulus: drop reset_n between clock edges.
  - Required: data_out=0, valid=0, busy=0, underflow_cnt=0 and s_ready=1 immediately.
  - After release, tx_start with an empty FIFO stays in PRIME with no outputs.
